// File: rtl/lfsr_gen_pkg.sv
// Shared constants for lfsr_gen: feedback modes, the maximal-length tap table
// for 4..32-bit registers, and the Galois mask derived from it.
package lfsr_gen_pkg;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_ADV
  } lfsr_op_e;

  // Each tap t of the polynomial sets bit (t-1) of the mask.
  function automatic logic [31:0] tap_mask(input int width);
    case (width)
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0060;
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      16:      tap_mask = 32'h0000_D008;
      17:      tap_mask = 32'h0001_2000;
      18:      tap_mask = 32'h0002_0400;
      19:      tap_mask = 32'h0004_0023;
      20:      tap_mask = 32'h0009_0000;
      21:      tap_mask = 32'h0014_0000;
      22:      tap_mask = 32'h0030_0000;
      23:      tap_mask = 32'h0042_0000;
      24:      tap_mask = 32'h00E1_0000;
      25:      tap_mask = 32'h0120_0000;
      26:      tap_mask = 32'h0200_0023;
      27:      tap_mask = 32'h0400_0013;
      28:      tap_mask = 32'h0900_0000;
      29:      tap_mask = 32'h1400_0000;
      30:      tap_mask = 32'h2000_0029;
      31:      tap_mask = 32'h4800_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

  // Coefficients below x^width: every tap t moves to bit t, plus the x^0 term.
  function automatic logic [31:0] poly_mask(input int width);
    logic [63:0] full;
    logic [63:0] keep;
    full = {31'd0, tap_mask(width), 1'b1};
    keep = (64'd1 << width) - 64'd1;
    poly_mask = 32'(full & keep);
  endfunction

endpackage

// File: rtl/lfsr_gen_pulse_sync.sv
// Two-flop synchroniser plus delay flop on the asynchronous pulse input;
// adv_ev is a single-cycle rising-edge event in the clk domain.
module lfsr_gen_pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic adv_ev
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign adv_ev = s2 & ~s3;

endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci/Galois LFSR with seed load, free-run and synchronised pulse advance.
// Optional advance counter on step_cnt when LFSR_GEN_STEP_CNT_EN is defined.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               MODE  = MODE_FIB,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h5EED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             run,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             wrap,
  output logic             seed_err,
  output logic [31:0]      step_cnt
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] POLY = WIDTH'(poly_mask(WIDTH));

  logic             adv_ev;
  logic [WIDTH-1:0] act_seed;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_val;
  logic             zero_seed;
  lfsr_op_e         op;

  lfsr_gen_pulse_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pulse  (pulse),
    .adv_ev (adv_ev)
  );

  generate
    if (MODE == MODE_GAL) begin : g_gal
      assign nxt = {word[WIDTH-2:0], 1'b0} ^ (word[WIDTH-1] ? POLY : '0);
    end else begin : g_fib
      assign nxt = {word[WIDTH-2:0], ^(word & TAPS)};
    end
  endgenerate

  // Pulse events that collide with a load or with run are dropped, never queued.
  always_comb begin
    op = OP_HOLD;
    if (seed_load)          op = OP_LOAD;
    else if (run || adv_ev) op = OP_ADV;
  end

  assign zero_seed = (seed_in == '0);
  assign load_val  = zero_seed ? SEED : seed_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word       <= SEED;
      act_seed   <= SEED;
      word_valid <= 1'b0;
      wrap       <= 1'b0;
      seed_err   <= 1'b0;
    end else begin
      word_valid <= (op == OP_ADV);
      wrap       <= (op == OP_ADV) && (nxt == act_seed);
      seed_err   <= (op == OP_LOAD) && zero_seed;
      case (op)
        OP_LOAD: begin
          word     <= load_val;
          act_seed <= load_val;
        end
        OP_ADV:  word <= nxt;
        default: ;
      endcase
    end
  end

`ifdef LFSR_GEN_STEP_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)              cnt_q <= '0;
    else if (op == OP_LOAD)  cnt_q <= '0;
    else if (op == OP_ADV)   cnt_q <= cnt_q + 32'd1;
  end

  assign step_cnt = cnt_q;
`else
  assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Randomised + directed bench for lfsr_gen: 16-bit Fibonacci, 16-bit Galois and
// 4-bit Fibonacci instances share stimulus and are checked against a polynomial model.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pulse = 1'b0;
  logic        run = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;

  logic [15:0] w_f, w_g;
  logic [3:0]  w_4;
  logic [2:0]  vld, wrp, err;
  logic [31:0] cnt_f, cnt_g, cnt_4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(16), .MODE(0)) d_f (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .run(run), .seed_load(seed_load),
    .seed_in(seed_in), .word(w_f), .word_valid(vld[0]), .wrap(wrp[0]),
    .seed_err(err[0]), .step_cnt(cnt_f));

  lfsr_gen #(.WIDTH(16), .MODE(1)) d_g (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .run(run), .seed_load(seed_load),
    .seed_in(seed_in), .word(w_g), .word_valid(vld[1]), .wrap(wrp[1]),
    .seed_err(err[1]), .step_cnt(cnt_g));

  lfsr_gen #(.WIDTH(4), .MODE(0)) d_4 (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .run(run), .seed_load(seed_load),
    .seed_in(seed_in[3:0]), .word(w_4), .word_valid(vld[2]), .wrap(wrp[2]),
    .seed_err(err[2]), .step_cnt(cnt_4));

`ifdef LFSR_GEN_STEP_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // Reference model: per instance 0 = fib16, 1 = gal16, 2 = fib4.
  localparam logic [31:0] SD [3] = '{32'h5EED, 32'h5EED, 32'hD};
  localparam int T16 [4] = '{16, 15, 13, 4};
  localparam int T4  [2] = '{4, 3};

  logic [31:0] m_word [3];
  logic [31:0] m_seed [3];
  logic [31:0] m_cnt  [3];
  logic        m_vld  [3];
  logic        m_wrap [3];
  logic        m_err  [3];
  logic [2:0]  ph;  // pulse as seen at the last three edges, newest in bit 0

  function automatic logic [31:0] lmask(input int i);
    return (i == 2) ? 32'hF : 32'hFFFF;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] w, input int i);
    logic [31:0] r;
    logic        fb;
    if (i == 1) begin
      // multiply by x modulo x^16 + x^15 + x^13 + x^4 + 1
      r = w << 1;
      if (r[16]) r = r ^ 32'h0001_A011;
    end else begin
      fb = 1'b0;
      if (i == 0) for (int t = 0; t < 4; t++) fb = fb ^ w[T16[t]-1];
      else        for (int t = 0; t < 2; t++) fb = fb ^ w[T4[t]-1];
      r = (w << 1) | 32'(fb);
    end
    return r & lmask(i);
  endfunction

  task automatic model_step();
    logic        ev;
    logic [31:0] sv;
    if (!rst_n) begin
      ph = '0;
      for (int i = 0; i < 3; i++) begin
        m_word[i] = SD[i]; m_seed[i] = SD[i]; m_cnt[i] = '0;
        m_vld[i] = 1'b0; m_wrap[i] = 1'b0; m_err[i] = 1'b0;
      end
    end else begin
      ev = ph[1] & ~ph[2];
      ph = {ph[1:0], pulse};
      for (int i = 0; i < 3; i++) begin
        m_vld[i] = 1'b0; m_wrap[i] = 1'b0; m_err[i] = 1'b0;
        sv = 32'(seed_in) & lmask(i);
        if (seed_load) begin
          m_err[i]  = (sv == 0);
          if (sv == 0) sv = SD[i];
          m_word[i] = sv;
          m_seed[i] = sv;
          m_cnt[i]  = '0;
        end else if (run || ev) begin
          m_word[i] = m_next(m_word[i], i);
          m_vld[i]  = 1'b1;
          m_wrap[i] = (m_word[i] == m_seed[i]);
          if (CNT_ON) m_cnt[i] = m_cnt[i] + 32'd1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] o_word(input int i);
    case (i)
      0:       return 32'(w_f);
      1:       return 32'(w_g);
      default: return 32'(w_4);
    endcase
  endfunction

  function automatic logic [31:0] o_cnt(input int i);
    case (i)
      0:       return cnt_f;
      1:       return cnt_g;
      default: return cnt_4;
    endcase
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("word%0d", i), o_word(i), m_word[i]);
      chk($sformatf("nonzero%0d", i), 32'(o_word(i) != 0), 32'd1);
      chk($sformatf("valid%0d", i), 32'(vld[i]), 32'(m_vld[i]));
      chk($sformatf("wrap%0d", i), 32'(wrp[i]), 32'(m_wrap[i]));
      chk($sformatf("seed_err%0d", i), 32'(err[i]), 32'(m_err[i]));
      chk($sformatf("step_cnt%0d", i), o_cnt(i), m_cnt[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int          n;
    logic [15:0] seen;

    // reset
    repeat (3) cyc();
    chk("rst_word", 32'(w_f), 32'h5EED);
    rst_n = 1'b1;
    cyc();

    // single pulse: sampled at N, word changes at N+2
    pulse = 1'b1; cyc();
    pulse = 1'b0; cyc();
    chk("pls_n1", 32'(w_f), 32'h5EED);
    cyc();
    chk("pls_n2", 32'(w_f), 32'hBDDB);
    chk("pls_vld", 32'(vld[0]), 32'd1);
    cyc();
    chk("pls_vld_off", 32'(vld[0]), 32'd0);

    // Galois free-run from reset
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; run = 1'b1; cyc();
    chk("gal_1", 32'(w_g), 32'hBDDA);
    cyc();
    chk("gal_2", 32'(w_g), 32'hDBA5);
    chk("gal_vld", 32'(vld[1]), 32'd1);
    run = 1'b0; cyc();

    // zero seed load, then load colliding with run
    seed_load = 1'b1; seed_in = 16'h0000; cyc();
    seed_load = 1'b0;
    chk("zload_word", 32'(w_f), 32'h5EED);
    chk("zload_err", 32'(err[0]), 32'd1);
    cyc();
    chk("zload_err_off", 32'(err[0]), 32'd0);
    seed_load = 1'b1; seed_in = 16'h1234; run = 1'b1; cyc();
    seed_load = 1'b0; run = 1'b0;
    chk("load_run_word", 32'(w_f), 32'h1234);
    chk("load_run_vld", 32'(vld[0]), 32'd0);

    // held pulse gives one advance
    n = 0;
    pulse = 1'b1;
    repeat (20) begin cyc(); n += int'(vld[0]); end
    pulse = 1'b0;
    repeat (4) begin cyc(); n += int'(vld[0]); end
    chk("held_pulse", 32'(n), 32'd1);

    // reset swallows an in-flight edge
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; cyc();
    pulse = 1'b1; cyc();
    pulse = 1'b0; rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin cyc(); n += int'(vld[0]); end
    chk("rst_flight_adv", 32'(n), 32'd0);
    chk("rst_flight_word", 32'(w_f), 32'h5EED);

    // full 4-bit period from seed 1
    seed_load = 1'b1; seed_in = 16'h0001; cyc();
    seed_load = 1'b0; run = 1'b1;
    seen = '0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      chk("p4_uniq", 32'(seen[w_4]), 32'd0);
      seen[w_4] = 1'b1;
      chk("p4_wrap", 32'(wrp[2]), 32'(k == 15));
    end
    chk("p4_end", 32'(w_4), 32'h1);
    chk("p4_cover", 32'($countones(seen)), 32'd15);
    run = 1'b0; cyc();

    // randomised mix
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      run       = ($urandom_range(0, 3) == 0);
      seed_load = ($urandom_range(0, 19) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 2) == 0) pulse = ~pulse;
      cyc();
    end
    rst_n = 1'b1; run = 1'b0; seed_load = 1'b0; pulse = 1'b0;
    repeat (4) cyc();

    // advance counter
    seed_load = 1'b1; seed_in = 16'hACE1; cyc();
    seed_load = 1'b0; run = 1'b1;
    repeat (100) cyc();
    run = 1'b0; cyc();
    chk("cnt_100", cnt_f, CNT_ON ? 32'd100 : 32'd0);
    seed_load = 1'b1; cyc();
    seed_load = 1'b0;
    chk("cnt_clr", cnt_f, 32'd0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16, LFSR length in bits; legal range 4..32.
REQ-002 Parameter MODE, default 0, feedback form: 0 = Fibonacci, 1 = Galois.
REQ-003 Parameter SEED, default 16'h5EED zero-extended to WIDTH, reset and fallback seed; nonzero.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 pulse  in  1  asynchronous advance request, rising-edge sensitive.
REQ-007 run  in  1  synchronous free-run enable; one advance per cycle while high.
REQ-008 seed_load  in  1  synchronous strobe; loads seed_in.
REQ-009 seed_in  in  WIDTH  seed value for seed_load.
REQ-010 word  out  WIDTH  current LFSR state.
REQ-011 word_valid  out  1  one-cycle strobe, high the cycle after any advance.
REQ-012 wrap  out  1  one-cycle strobe, high when an advance returns word to the active seed.
REQ-013 seed_err  out  1  one-cycle strobe, high the cycle after a zero seed_in load.
REQ-014 step_cnt  out  32  advances since reset or last load (see Configuration).

Function
REQ-015 pulse SHALL pass through a 2-flop synchroniser (s1, s2) plus delay flop s3; an advance event is s2 & !s3.
REQ-016 pulse first sampled high at edge N SHALL update word at edge N+2; a held-high pulse SHALL produce exactly one advance.
REQ-017 Fibonacci advance: word <= {word[WIDTH-2:0], fb}, fb = XOR of word bits at tap positions (tap-1) from the package table.
REQ-018 Galois advance: word <= (word << 1) ^ (word[WIDTH-1] ? POLY_MASK : 0), mask = polynomial coefficients below x^WIDTH.
REQ-019 Priority each cycle SHALL be: seed_load > run > synchronised pulse edge; at most one state change per cycle.
REQ-020 While run=1, pulse edges SHALL be discarded, not queued.
REQ-021 seed_load with nonzero seed_in SHALL set word and the active-seed register to seed_in at the next edge; word_valid stays low.
REQ-022 seed_load with seed_in=0 SHALL load SEED into word and the active seed, and pulse seed_err.
REQ-023 wrap SHALL assert coincident with the word_valid of the advance whose result equals the active seed.
REQ-024 word SHALL never hold zero; states are reachable only via SEED, nonzero loads, and advances.

Reset
REQ-025 While rst_n=0 at an edge: word=SEED, active seed=SEED, s1/s2/s3=0, word_valid=0, wrap=0, seed_err=0, step_cnt=0.
REQ-026 Reset mid-operation SHALL discard any in-flight pulse edge; the first post-reset advance requires a fresh pulse rising edge.

Configuration
REQ-027 With macro LFSR_GEN_STEP_CNT_EN defined: step_cnt increments by 1 per advance, wraps 0xFFFFFFFF->0, clears on seed_load.
REQ-028 Without LFSR_GEN_STEP_CNT_EN: no counter logic; step_cnt is driven constant 0; port list unchanged.

Structure
REQ-029 Package lfsr_gen_pkg SHALL hold the maximal-length tap table for WIDTH 4..32 (WIDTH=16: taps 16,15,13,4), the POLY_MASK derivation function, and MODE constants.
REQ-030 Sub-module lfsr_gen_pulse_sync SHALL hold the synchroniser and edge detector; the next-state logic stays in lfsr_gen.

Verification
REQ-031 WIDTH=16, MODE=0, reset then one pulse -> word 0x5EED -> 0xBDDB at edge N+2; word_valid high one cycle.
REQ-032 WIDTH=16, MODE=1, run=1 for 2 cycles -> word 0x5EED -> 0xBDDA -> 0xDBA5; two word_valid strobes.
REQ-033 WIDTH=4, MODE=0, seed_load 0x1, run=1 -> wrap on the 15th advance, word=0x1; all 15 nonzero states visited once.
REQ-034 seed_load with seed_in=0x0000 -> word=0x5EED, seed_err one cycle; seed_load and run together -> load wins, no advance.
REQ-035 pulse held high 20 cycles -> exactly one advance; pulse rising edge then rst_n low at edge N+1 -> word=0x5EED, no advance.
REQ-036 LFSR_GEN_STEP_CNT_EN on: 100 advances -> step_cnt=100; seed_load -> 0. Macro off: step_cnt=0 throughout.
